// File: rtl/counter_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | counter_ctrl : start/pause/abort run counter, one-shot or auto-reload.   |
// | Optional prescaler enabled by macro PRESCALE_EN.      Revision: 1.0      |
// +--------------------------------------------------------------------------+
module counter_ctrl #(
  parameter int WIDTH = 4,
  parameter int PRESC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic [WIDTH-1:0] limit,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic [7:0]       wraps
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             mode_q, mode_d;
  logic [7:0]       wraps_q, wraps_d;
  logic             done_q, done_d;
  logic             tick;

  if (PRESC < 2 || PRESC > 16) begin : g_presc_check
    $error("counter_ctrl: PRESC must be in 2..16");
  end

`ifdef PRESCALE_EN
  logic [3:0] pre_q, pre_d;
`endif

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    lim_d   = lim_q;
    mode_d  = mode_q;
    wraps_d = wraps_q;
    done_d  = 1'b0;
`ifdef PRESCALE_EN
    pre_d   = pre_q;
    tick    = (pre_q == 4'(PRESC - 1));
`else
    tick    = 1'b1;
`endif

    if (abort) begin
      state_d = S_IDLE;
      out_d   = '0;
`ifdef PRESCALE_EN
      pre_d   = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_RUN;
            out_d   = '0;
            lim_d   = limit;
            mode_d  = auto_reload;
            wraps_d = '0;
`ifdef PRESCALE_EN
            pre_d   = '0;
`endif
          end
        end
        S_RUN: begin
          if (pause) begin
            state_d = S_HOLD;
          end else begin
`ifdef PRESCALE_EN
            pre_d = tick ? 4'd0 : pre_q + 4'd1;
`endif
            if (tick) begin
              if (out_q == lim_q) begin
                done_d = 1'b1;
                if (mode_q) begin
                  out_d   = '0;
                  wraps_d = (wraps_q == 8'hFF) ? wraps_q : wraps_q + 8'd1;
                end else begin
                  state_d = S_DONE;
                end
              end else begin
                out_d = out_q + WIDTH'(1);
              end
            end
          end
        end
        S_HOLD: begin
          // Leaving HOLD costs one edge with no count, keeping the pause exact.
          if (!pause) state_d = S_RUN;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      lim_q   <= '0;
      mode_q  <= 1'b0;
      wraps_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      lim_q   <= lim_d;
      mode_q  <= mode_d;
      wraps_q <= wraps_d;
      done_q  <= done_d;
    end
  end

`ifdef PRESCALE_EN
  always_ff @(posedge clk) begin
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end
`endif

  assign out   = out_q;
  assign busy  = (state_q == S_RUN) || (state_q == S_HOLD);
  assign done  = done_q;
  assign wraps = wraps_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_counter_ctrl : directed self-checking bench for counter_ctrl.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       pause;
  logic       abort;
  logic [3:0] limit;
  logic       auto_reload;
  logic [3:0] out;
  logic       busy;
  logic       done;
  logic [7:0] wraps;

  int n_checks = 0;
  int n_errors = 0;

  counter_ctrl #(.WIDTH(4), .PRESC(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pause       (pause),
    .abort       (abort),
    .limit       (limit),
    .auto_reload (auto_reload),
    .out         (out),
    .busy        (busy),
    .done        (done),
    .wraps       (wraps)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] lim, input logic ar);
    limit       = lim;
    auto_reload = ar;
    start       = 1'b1;
    step();
    start       = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
    limit = 4'd0; auto_reload = 1'b0;
    step(); step();
    check("rst_out",   32'(out),   32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_wraps", 32'(wraps), 32'd0);
    rst = 1'b0;
    step();
    check("idle_out", 32'(out), 32'd0);

`ifdef PRESCALE_EN
    do_start(4'd2, 1'b0);
    check("pre_start_out", 32'(out), 32'd0);
    for (int k = 1; k <= 11; k++) begin
      step();
      check("pre_out", 32'(out), 32'(k / 4));
      check("pre_done", 32'(done), 32'd0);
    end
    step();
    check("pre_term_done", 32'(done), 32'd1);
    check("pre_term_out",  32'(out),  32'd2);
    check("pre_term_busy", 32'(busy), 32'd0);
`else
    // One-shot to 5
    do_start(4'd5, 1'b0);
    check("os_start_out",  32'(out),  32'd0);
    check("os_start_busy", 32'(busy), 32'd1);
    check("os_start_done", 32'(done), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("os_out",  32'(out),  32'(k));
      check("os_done", 32'(done), 32'd0);
    end
    step();
    check("os_term_out",  32'(out),  32'd5);
    check("os_term_done", 32'(done), 32'd1);
    check("os_term_busy", 32'(busy), 32'd0);
    step();
    check("os_after_done", 32'(done), 32'd0);
    check("os_hold_out",   32'(out),  32'd5);

    // Restart from DONE in auto-reload mode, limit 3
    do_start(4'd3, 1'b1);
    check("ar_start_out",   32'(out),   32'd0);
    check("ar_start_wraps", 32'(wraps), 32'd0);
    check("ar_start_busy",  32'(busy),  32'd1);
    for (int k = 1; k <= 12; k++) begin
      step();
      check("ar_out",   32'(out),   32'(k % 4));
      check("ar_done",  32'(done),  32'((k % 4) == 0));
      check("ar_wraps", 32'(wraps), 32'(k / 4));
    end
    step(); step(); step();
    check("ar_pre_abort_out", 32'(out), 32'd3);
    // Abort on what would be a terminal edge
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_out",   32'(out),   32'd0);
    check("abort_done",  32'(done),  32'd0);
    check("abort_busy",  32'(busy),  32'd0);
    check("abort_wraps", 32'(wraps), 32'd3);

    // Pause with start ignored while paused
    do_start(4'd9, 1'b0);
    for (int k = 1; k <= 4; k++) step();
    check("pz_out4", 32'(out), 32'd4);
    pause = 1'b1; start = 1'b1; limit = 4'd2; auto_reload = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("pz_hold_out",  32'(out),  32'd4);
      check("pz_hold_busy", 32'(busy), 32'd1);
    end
    pause = 1'b0; start = 1'b0;
    step();
    check("pz_resume_out", 32'(out), 32'd4);
    for (int k = 5; k <= 9; k++) begin
      step();
      check("pz_out", 32'(out), 32'(k));
    end
    step();
    check("pz_term_done", 32'(done), 32'd1);
    check("pz_term_out",  32'(out),  32'd9);
    check("pz_term_busy", 32'(busy), 32'd0);

    // Abort at out = 7, limit 15
    do_start(4'd15, 1'b1);
    for (int k = 1; k <= 23; k++) step();
    check("ab7_out",   32'(out),   32'd7);
    check("ab7_wraps", 32'(wraps), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab7_after_out",   32'(out),   32'd0);
    check("ab7_after_busy",  32'(busy),  32'd0);
    check("ab7_after_done",  32'(done),  32'd0);
    check("ab7_after_wraps", 32'(wraps), 32'd1);

    // Reset at out = 7 overriding a simultaneous start
    do_start(4'd15, 1'b1);
    for (int k = 1; k <= 23; k++) step();
    check("rs7_out", 32'(out), 32'd7);
    rst = 1'b1; start = 1'b1; limit = 4'd1;
    step();
    rst = 1'b0; start = 1'b0;
    check("rs7_out_after",   32'(out),   32'd0);
    check("rs7_busy_after",  32'(busy),  32'd0);
    check("rs7_done_after",  32'(done),  32'd0);
    check("rs7_wraps_after", 32'(wraps), 32'd0);

    // Limit 0 one-shot: first tick is terminal
    do_start(4'd0, 1'b0);
    check("z_start_busy", 32'(busy), 32'd1);
    step();
    check("z_done", 32'(done), 32'd1);
    check("z_out",  32'(out),  32'd0);
    check("z_busy", 32'(busy), 32'd0);

    // Limit 15 one-shot: full-range count
    do_start(4'd15, 1'b0);
    for (int k = 1; k <= 15; k++) step();
    check("m_out15",  32'(out),  32'd15);
    check("m_done15", 32'(done), 32'd0);
    step();
    check("m_term_done", 32'(done), 32'd1);
    check("m_term_out",  32'(out),  32'd15);

    // Limit 0 auto-reload: wraps saturates at 255
    do_start(4'd0, 1'b1);
    step();
    check("sat_first_wraps", 32'(wraps), 32'd1);
    check("sat_first_done",  32'(done),  32'd1);
    for (int k = 2; k <= 300; k++) step();
    check("sat_wraps", 32'(wraps), 32'd255);
    check("sat_out",   32'(out),   32'd0);
    check("sat_done",  32'(done),  32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("sat_abort_done",  32'(done),  32'd0);
    check("sat_abort_wraps", 32'(wraps), 32'd255);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
